// File: rtl/parsed_msg_fifo.sv
// parsed_msg_fifo: first-word-fall-through buffer for complete parsed ITCH
// records between the parser output mux and the order-book/strategy consumers.
// The parser cannot be stalled, so a record arriving while the buffer is full
// (and nothing leaves that cycle) is dropped. Each drop is counted and latched
// in a sticky overflow flag.
// Optional build macro PARSED_MSG_FIFO_TYPE_FILTER_EN adds a per-type input
// mask (type_mask) and a counter of filtered records (filtered_count).
module parsed_msg_fifo #(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        in_type,
  input  logic [63:0]       in_order_ref,
  input  logic              in_side,
  input  logic [31:0]       in_shares,
  input  logic [31:0]       in_price,
  input  logic [63:0]       in_new_order_ref,
  input  logic [47:0]       in_timestamp,
  input  logic [63:0]       in_misc_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_type,
  output logic [63:0]       out_order_ref,
  output logic              out_side,
  output logic [31:0]       out_shares,
  output logic [31:0]       out_price,
  output logic [63:0]       out_new_order_ref,
  output logic [47:0]       out_timestamp,
  output logic [63:0]       out_misc_data,
  output logic [LVL_W-1:0]  level,
  output logic [CNT_W-1:0]  drop_count,
`ifdef PARSED_MSG_FIFO_TYPE_FILTER_EN
  input  logic [15:0]       type_mask,
  output logic [CNT_W-1:0]  filtered_count,
`endif
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  // 309-bit record: 4+64+1+32+32+64+48+64
  typedef struct packed {
    logic [3:0]  typ;
    logic [63:0] order_ref;
    logic        side;
    logic [31:0] shares;
    logic [31:0] price;
    logic [63:0] new_order_ref;
    logic [47:0] timestamp;
    logic [63:0] misc_data;
  } rec_t;

  rec_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  logic full, empty, accept, push, pop, drop;
  rec_t in_rec, head;

`ifdef PARSED_MSG_FIFO_TYPE_FILTER_EN
  logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic             filtered;

  // Masked-out types are discarded before the full check, so they never count as drops
  always_comb begin
    accept     = in_valid && type_mask[in_type];
    filtered   = in_valid && !type_mask[in_type];
    filt_cnt_d = filt_cnt_q;
    if (filtered && (filt_cnt_q != '1)) filt_cnt_d = filt_cnt_q + 1'b1;
  end

  // Saturating count of records rejected by the type mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) filt_cnt_q <= '0;
    else     filt_cnt_q <= filt_cnt_d;
  end

  assign filtered_count = filt_cnt_q;
`else
  assign accept = in_valid;
`endif

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push  = accept && (!full || pop);
  assign drop  = accept && full && !pop;

  assign in_rec = '{typ:           in_type,
                    order_ref:     in_order_ref,
                    side:          in_side,
                    shares:        in_shares,
                    price:         in_price,
                    new_order_ref: in_new_order_ref,
                    timestamp:     in_timestamp,
                    misc_data:     in_misc_data};

  // Next-state for pointers, occupancy and drop bookkeeping
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Control state; reset discards everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Record storage, written at the write pointer on every accepted push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_rec;
    end
  end

  // Fall-through head: the entry at the read pointer, held while not popped
  assign head              = mem_q[rd_ptr_q];
  assign out_valid         = !empty;
  assign out_type          = head.typ;
  assign out_order_ref     = head.order_ref;
  assign out_side          = head.side;
  assign out_shares        = head.shares;
  assign out_price         = head.price;
  assign out_new_order_ref = head.new_order_ref;
  assign out_timestamp     = head.timestamp;
  assign out_misc_data     = head.misc_data;
  assign level             = level_q;
  assign drop_count        = drop_cnt_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_parsed_msg_fifo.sv
// Directed bench for parsed_msg_fifo (DEPTH=4). Each record's fields are
// derived from a small integer id so output order can be verified field by field.
module tb_parsed_msg_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [3:0] in_type = '0;
  logic [63:0] in_order_ref = '0;
  logic in_side = 1'b0;
  logic [31:0] in_shares = '0;
  logic [31:0] in_price = '0;
  logic [63:0] in_new_order_ref = '0;
  logic [47:0] in_timestamp = '0;
  logic [63:0] in_misc_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [3:0] out_type;
  logic [63:0] out_order_ref;
  logic out_side;
  logic [31:0] out_shares;
  logic [31:0] out_price;
  logic [63:0] out_new_order_ref;
  logic [47:0] out_timestamp;
  logic [63:0] out_misc_data;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] drop_count;
  logic overflow;
`ifdef PARSED_MSG_FIFO_TYPE_FILTER_EN
  logic [15:0] type_mask = 16'hFFFF;
  logic [CNT_W-1:0] filtered_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parsed_msg_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_type(in_type), .in_order_ref(in_order_ref),
    .in_side(in_side), .in_shares(in_shares), .in_price(in_price),
    .in_new_order_ref(in_new_order_ref), .in_timestamp(in_timestamp),
    .in_misc_data(in_misc_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_order_ref(out_order_ref), .out_side(out_side),
    .out_shares(out_shares), .out_price(out_price),
    .out_new_order_ref(out_new_order_ref), .out_timestamp(out_timestamp),
    .out_misc_data(out_misc_data),
    .level(level), .drop_count(drop_count),
`ifdef PARSED_MSG_FIFO_TYPE_FILTER_EN
    .type_mask(type_mask), .filtered_count(filtered_count),
`endif
    .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] f_oref(input int id);
    return 64'hA5A5_0000_0000_0000 | 64'(id);
  endfunction

  // Advance one active edge, then settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present record id with type typ for the next edge
  task automatic drive(input int id, input logic [3:0] typ);
    in_valid         = 1'b1;
    in_type          = typ;
    in_order_ref     = f_oref(id);
    in_side          = id[0];
    in_shares        = 32'(id + 7);
    in_price         = 32'(id * 100);
    in_new_order_ref = ~f_oref(id);
    in_timestamp     = 48'(id) << 8;
    in_misc_data     = {32'(id), 32'(id)};
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic check_head(input string tag, input int id, input logic [3:0] typ);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".type"}, 64'(out_type), 64'(typ));
    chk({tag, ".oref"}, out_order_ref, f_oref(id));
    chk({tag, ".side"}, 64'(out_side), 64'(id[0]));
    chk({tag, ".shares"}, 64'(out_shares), 64'(id + 7));
    chk({tag, ".price"}, 64'(out_price), 64'(id * 100));
    chk({tag, ".noref"}, out_new_order_ref, ~f_oref(id));
    chk({tag, ".ts"}, 64'(out_timestamp), 64'(id) << 8);
    chk({tag, ".misc"}, out_misc_data, {32'(id), 32'(id)});
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.level", 64'(level), 64'd0);
    chk("rst.drop", 64'(drop_count), 64'd0);
    chk("rst.ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single record: type 1, price 1000, consumer ready
    out_ready = 1'b1;
    drive(10, 4'h1);
    tick();
    idle();
    check_head("single", 10, 4'h1);
    chk("single.price1000", 64'(out_price), 64'd1000);
    chk("single.level1", 64'(level), 64'd1);
    tick();
    chk("single.level0", 64'(level), 64'd0);
    chk("single.empty", 64'(out_valid), 64'd0);
    chk("single.drop", 64'(drop_count), 64'd0);

    // Backpressure: three records held, head stable
    out_ready = 1'b0;
    drive(2, 4'h2); tick();
    drive(3, 4'h3); tick();
    drive(4, 4'h4); tick();
    idle();
    chk("bp.level3", 64'(level), 64'd3);
    check_head("bp.hold0", 2, 4'h2);
    tick();
    check_head("bp.hold1", 2, 4'h2);
    tick();
    check_head("bp.hold2", 2, 4'h2);
    out_ready = 1'b1;
    #1;
    check_head("bp.out2", 2, 4'h2);
    tick();
    check_head("bp.out3", 3, 4'h3);
    tick();
    check_head("bp.out4", 4, 4'h4);
    tick();
    chk("bp.empty", 64'(out_valid), 64'd0);
    chk("bp.level0", 64'(level), 64'd0);

    // Overflow: six pushes into a 4-deep FIFO with no consumer
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(40 + i, 4'(40 + i));
      tick();
    end
    idle();
    chk("ovf.level", 64'(level), 64'd4);
    chk("ovf.drop", 64'(drop_count), 64'd2);
    chk("ovf.flag", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("ovf.out%0d", i), 40 + i, 4'(40 + i));
      tick();
    end
    chk("ovf.drained", 64'(out_valid), 64'd0);
    chk("ovf.drop_hold", 64'(drop_count), 64'd2);
    chk("ovf.flag_sticky", 64'(overflow), 64'd1);

    // Full with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(20 + i, 4'(20 + i));
      tick();
    end
    chk("fullpp.level_pre", 64'(level), 64'd4);
    drive(24, 4'(24));
    out_ready = 1'b1;
    #1;
    check_head("fullpp.head20", 20, 4'(20));
    tick();
    idle();
    out_ready = 1'b0;
    chk("fullpp.level", 64'(level), 64'd4);
    chk("fullpp.drop", 64'(drop_count), 64'd2);
    out_ready = 1'b1;
    #1;
    for (int i = 1; i < 5; i++) begin
      check_head($sformatf("fullpp.out%0d", i), 20 + i, 4'(20 + i));
      tick();
    end
    chk("fullpp.drained", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges with three records queued
    out_ready = 1'b0;
    drive(30, 4'(30)); tick();
    drive(31, 4'(31)); tick();
    drive(32, 4'(32)); tick();
    idle();
    chk("arst.level_pre", 64'(level), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.valid", 64'(out_valid), 64'd0);
    chk("arst.level", 64'(level), 64'd0);
    chk("arst.drop", 64'(drop_count), 64'd0);
    chk("arst.ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("arst.still_empty", 64'(out_valid), 64'd0);
    drive(33, 4'(33));
    tick();
    idle();
    check_head("arst.first", 33, 4'(33));
    chk("arst.level1", 64'(level), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("arst.drained", 64'(out_valid), 64'd0);

`ifdef PARSED_MSG_FIFO_TYPE_FILTER_EN
    // Type filter: only type 1 passes
    type_mask = 16'h0002;
    out_ready = 1'b0;
    drive(50, 4'h1); tick();
    drive(51, 4'h2); tick();
    drive(52, 4'h1); tick();
    idle();
    chk("filt.level", 64'(level), 64'd2);
    chk("filt.count", 64'(filtered_count), 64'd1);
    chk("filt.drop", 64'(drop_count), 64'd0);
    out_ready = 1'b1;
    #1;
    check_head("filt.out0", 50, 4'h1);
    tick();
    check_head("filt.out1", 52, 4'h1);
    tick();
    chk("filt.drained", 64'(out_valid), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parsed_msg_fifo.md
Name: parsed_msg_fifo

Overview:
- Parametrised successor to the single-entry parsed-field latch.
- Buffers complete parsed ITCH records (type, order_ref, side, shares, price, new_order_ref, timestamp, misc_data) in a DEPTH-entry first-word-fall-through FIFO.
- Presents records downstream with a valid/ready handshake; the parser cannot stall.
- Sits between the parser output mux and the order-book/strategy consumers. Overflow drops are counted, never silently lost.

Parameters:
- DEPTH, 4, number of record entries; power of two, >= 2.
- CNT_W, 16, width of the drop counter.
- LVL_W, $clog2(DEPTH)+1, width of the occupancy output (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  parser record strobe, 1-cycle pulse per record
- in_type  in  4  parsed message type
- in_order_ref  in  64  order reference
- in_side  in  1  buy/sell
- in_shares  in  32  share count
- in_price  in  32  price
- in_new_order_ref  in  64  replacement order reference
- in_timestamp  in  48  timestamp
- in_misc_data  in  64  type-specific extra data
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts head record
- out_type, out_order_ref, out_side, out_shares, out_price, out_new_order_ref, out_timestamp, out_misc_data  out  4/64/1/32/32/64/48/64  head record fields
- level  out  LVL_W  current occupancy, 0..DEPTH
- drop_count  out  CNT_W  records discarded because the FIFO was full; saturating
- overflow  out  1  sticky; set on the first drop, cleared only by reset

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, level=0, drop_count=0, overflow=0.
  - All storage entries and out_* fields = 0; read/write pointers = 0.
- Storage: DEPTH-entry register array of 309-bit records, indexed by read/write pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- Full/empty: full = (level==DEPTH); empty = (level==0).
- Push: occurs when in_valid && (!full || pop). Record written at wr_ptr; wr_ptr increments.
- Pop: occurs when out_valid && out_ready; rd_ptr increments.
- Level update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
- Simultaneous push and pop when full: both accepted; no drop.
- Simultaneous push and pop when empty: impossible, since out_valid=0, so push only.
- Drop: occurs when in_valid && full && !pop.
  - Record discarded; FIFO contents unchanged.
  - drop_count += 1, saturating at all-ones.
  - overflow <= 1.
- Output path:
  - out_valid = !empty (registered-state derived).
  - out_* = entry at rd_ptr.
- Latency: record pushed into an empty FIFO at edge N is visible (out_valid=1, fields valid) after edge N. Minimum in->out latency is 1 cycle.
- Stability: while out_valid && !out_ready, all out_* fields hold constant.
- Empty state: out_* show a stale entry; they are checked only when out_valid=1.
- Ordering: strict FIFO; no reordering, no merging.
- Reset mid-operation: all contents discarded immediately; no record is output after rst deasserts until a new push.
- Throughput: one push and one pop per cycle sustained.

Optional Feature:
- Macro: PARSED_MSG_FIFO_TYPE_FILTER_EN.
- Enabled:
  - Adds input type_mask [15:0].
  - A record with type_mask[in_type]==0 is discarded at input: no push, no drop count, no overflow.
  - Also adds output filtered_count [CNT_W-1:0], saturating, reset 0, incremented per filtered record.
  - Filtering is evaluated before the full check.
- Disabled: no extra ports; every in_valid record is pushed or dropped as above.

Test Plan:
- Single record, DEPTH=4: push type=4'h1, price=32'd1000 with out_ready=1 -> out_valid=1 the next cycle with those fields; level returns 1->0 after the pop edge; drop_count=0.
- Backpressure hold: push 3 records with out_ready=0 -> level=3, out_* = first record stable every cycle; raise out_ready -> records emerge in order over 3 cycles, then out_valid=0.
- Overflow: out_ready=0, push 6 records -> level=4, drop_count=2, overflow=1; drain -> records 1..4 out, 5 and 6 absent.
- Full with simultaneous push and pop: fill to 4, then one cycle in_valid=1 and out_ready=1 -> level stays 4, drop_count unchanged, new record appears 4th in output order.
- Async reset mid-stream: level=3, assert rst between edges -> out_valid, level, drop_count, overflow all 0 immediately; after release, the first push is output first.
- With PARSED_MSG_FIFO_TYPE_FILTER_EN: type_mask=16'h0002, push types 1,2,1 -> only the two type-1 records are output; filtered_count=1; drop_count=0.
